// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dm between the CPU data port (default priority) and an external master.
// Latency: CPU path combinational (0 cycles); ext granted same cycle when CPU idle, else after STARVE_MAX blocked cycles; ext_ack/ext_rdata one cycle after grant.
// Backpressure: CPU stalled on cycles the external master wins; ext holds ext_req until ext_gnt. `DMARB_LOCK_EN adds ext_lock burst ownership.
module dmem_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [31:0]       ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
`ifdef DMARB_LOCK_EN
    input  logic              ext_lock,
`endif
    output logic              ext_gnt,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    input  logic [DATA_W-1:0] dm_dout,
    output logic [15:0]       stall_cnt
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    logic [SW-1:0] starve;
    logic          lock_win;
    logic [15:0]   stall_q;

`ifdef DMARB_LOCK_EN
    logic lock_q;

    // Ownership persists only while the master keeps both request and lock high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= ext_gnt & ext_lock;
        end
    end

    assign lock_win = lock_q;
`else
    assign lock_win = 1'b0;
`endif

    assign ext_gnt   = ext_req & (~cpu_req | (starve == STARVE_TOP) | lock_win);
    assign cpu_stall = cpu_req & ext_gnt;

    assign dm_addr   = ext_gnt ? ext_addr[ADDR_W+1:2] : cpu_addr[ADDR_W+1:2];
    assign dm_din    = ext_gnt ? ext_wdata : cpu_wdata;
    assign dm_we     = ext_gnt ? ext_we : (cpu_req & cpu_we);
    assign cpu_rdata = dm_dout;
    assign stall_cnt = stall_q;

    // Byte-lane bits and bits above the memory size are don't-care (accesses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                                ext_addr[31:ADDR_W+2], ext_addr[1:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve <= '0;
        end else if (ext_req && !ext_gnt) begin
            if (starve != STARVE_TOP) begin
                starve <= starve + 1'b1;
            end
        end else begin
            starve <= '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ext_ack   <= 1'b0;
            ext_rdata <= '0;
        end else begin
            ext_ack <= ext_gnt;
            if (ext_gnt && !ext_we) begin
                ext_rdata <= dm_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= '0;
        end else if (cpu_stall && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the single-cycle CPU data port and an external master (debug loader / DMA). It sits between the CPU, the external master and `dm`, and drives `dm`'s write strobe, word address and write data. The CPU has default priority. The external master is guaranteed forward progress by a starvation counter that steals one cycle from the CPU by stalling it. Read data for the external master is registered; the CPU path stays combinational so single-cycle CPU timing is unchanged.

## Interface
Parameters:
- `ADDR_W`, 7: word-address width driven to `dm`.
- `DATA_W`, 32: data width.
- `STARVE_MAX`, 4: consecutive blocked cycles after which the external master wins; must be ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `cpu_req`  in  1  CPU load/store in the current cycle.
- `cpu_we`  in  1  CPU store.
- `cpu_addr`  in  32  CPU byte address.
- `cpu_wdata`  in  DATA_W  CPU store data.
- `cpu_rdata`  out  DATA_W  CPU load data, combinational from `dm_dout`.
- `cpu_stall`  out  1  CPU must hold PC and suppress commit this cycle.
- `ext_req`  in  1  external access request, held until granted.
- `ext_we`  in  1  external write.
- `ext_addr`  in  32  external byte address.
- `ext_wdata`  in  DATA_W  external write data.
- `ext_gnt`  out  1  external access performed this cycle.
- `ext_ack`  out  1  registered one-cycle pulse, cycle after `ext_gnt`.
- `ext_rdata`  out  DATA_W  registered read data, valid with `ext_ack` after a read.
- `dm_we`  out  1  memory write strobe.
- `dm_addr`  out  ADDR_W  memory word address.
- `dm_din`  out  DATA_W  memory write data.
- `dm_dout`  in  DATA_W  memory read data (combinational read).
- `stall_cnt`  out  16  saturating count of CPU stall cycles.

## Operation
- Grant is combinational:
  - `ext_gnt = ext_req & (~cpu_req | starve == STARVE_MAX)` (plus lock, see Configuration).
  - `cpu_stall = cpu_req & ext_gnt`.
- Mux, with `owner = ext_gnt`:
  - `dm_addr` is `ext_addr[ADDR_W+1:2]` when `ext_gnt`, else `cpu_addr[ADDR_W+1:2]`.
  - `dm_din` is `ext_wdata` when `ext_gnt`, else `cpu_wdata`.
  - `dm_we` is `ext_we` when `ext_gnt`, else `cpu_req & cpu_we`.
- Byte-address bits [1:0] are ignored; bits above ADDR_W+1 are ignored (wrap within memory).
- `cpu_rdata = dm_dout` always; meaningful only when `cpu_req & ~cpu_stall`.
- `starve` counter (width `$clog2(STARVE_MAX+1)`):
  - increments, saturating at STARVE_MAX, when `ext_req & ~ext_gnt`;
  - clears to 0 when `ext_gnt` or `~ext_req`.
- Ack path:
  - on `ext_gnt`, `ext_ack` <= 1 next cycle, else 0.
  - on `ext_gnt & ~ext_we`, `ext_rdata` <= `dm_dout`; otherwise `ext_rdata` holds.
- `stall_cnt` increments on each `cpu_stall` cycle, saturating at 16'hFFFF.
- Back-to-back external accesses are allowed. A request held high after a grant is a new request, and `starve` restarts from 0.
- Simultaneous CPU and external write to the same word: the granted side's write is the only one performed. A stalled CPU store is retried by the CPU next cycle, so it lands last.

## Timing
- Reset (async, `rstn`=0): `starve`=0, `ext_ack`=0, `ext_rdata`=0, `stall_cnt`=0, lock state=0. Combinational outputs follow their inputs.
- Writes take effect at the `clk` edge ending the `dm_we` cycle.
- External latency:
  - granted in cycle N with no CPU contention;
  - granted in cycle N+STARVE_MAX under continuous CPU traffic;
  - `ext_ack` and `ext_rdata` appear in the cycle after the grant.
- CPU load latency is 0 cycles when not stalled. At most 1 stall per STARVE_MAX+1 cycles (unlocked).
- Reset asserted mid-access aborts it. No `ext_ack` is produced for a grant whose following edge occurs in reset.

## Configuration
- `DMARB_LOCK_EN` defined:
  - adds input `ext_lock` (1 bit) and a lock flag;
  - the flag sets on `ext_gnt & ext_lock` and clears when `ext_req`=0 or `ext_lock`=0;
  - while the flag is set, `ext_gnt = ext_req` regardless of `cpu_req` (burst ownership, CPU stalled throughout).
- Undefined: no `ext_lock` port, no lock flag; arbitration is purely the starvation rule.

## Test plan
- Idle CPU: ext write 0xDEADBEEF to 0x40, then read 0x40 → `ext_gnt` same cycle each time, `ext_ack` next cycle, `ext_rdata`=0xDEADBEEF, `cpu_stall` never asserted.
- CPU `cpu_req`=1 every cycle, ext read held → `ext_gnt` in 5th cycle (STARVE_MAX=4), `cpu_stall`=1 exactly that cycle, `stall_cnt`=1.
- Contention on address 0x10: CPU store 0x11111111 blocked by a starved ext store 0x22222222 → ext write first, CPU retry next cycle; final mem[4]=0x11111111.
- Assert `rstn`=0 in the grant cycle of an ext read → `ext_ack`=0, `ext_rdata`=0, `starve`=0 after release.
- `stall_cnt` preloaded near saturation via forced stalls → holds at 0xFFFF.
- With `DMARB_LOCK_EN`: 4-word locked ext burst during CPU traffic → 4 consecutive grants, `cpu_stall`=1 for 4 cycles; lock drops when `ext_lock`=0.
